riscq_mem_loader: RTL and testbench

RISCQ_MEM_LOADER -- requirements
Module: riscq_mem_loader

---
 rtl/riscq_pkg.sv | 15 +
 rtl/riscq_mem_loader.sv | 111 +++++++++++
 tb/tb_riscq_mem_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscq_pkg.sv
// Shared definitions for the RISCQ memory loader: controller states and the
// default end-of-region marker.
package riscq_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        DONE = 2'd1,
        HOLD = 2'd2
    } loader_state_e;

    // Widest stream supported by the default marker; the loader slices it to DATA_W.
    localparam int              TERM_MAX_W    = 64;
    localparam logic [TERM_MAX_W-1:0] TERM_ALL_ONES = '1;

endpackage

// File: rtl/riscq_mem_loader.sv
// Streams words into NUM_REGIONS memories one after another; a terminator word
// closes the current region and moves on to the next.
module riscq_mem_loader
    import riscq_pkg::*;
#(
    parameter int                NUM_REGIONS = 2,
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] TERM_WORD   = TERM_ALL_ONES[DATA_W-1:0]
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cpu_rst,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_data_valid,
    output logic [ADDR_W-1:0]      o_waddr,
    output logic [DATA_W-1:0]      o_wdata,
    output logic [NUM_REGIONS-1:0] o_we,
    output logic [NUM_REGIONS-1:0] o_init_done,
    output logic                   o_all_done,
    output logic                   o_overflow_err,
    output logic [1:0]             o_region
);

    loader_state_e            state;
    loader_state_e            state_next;
    logic [ADDR_W-1:0]        addr;
    logic                     addr_full;
    logic [1:0]               region;
    logic                     active;
    logic                     term_seen;
    logic                     word_seen;
    logic                     last_region;
    logic [NUM_REGIONS-1:0]   region_sel;

    // HOLD behaves like LOAD as soon as the reload request is released, so the
    // word arriving in that same cycle is not lost.
    always_comb begin
        active      = i_cpu_rst && (state != DONE);
        term_seen   = active && i_data_valid && (i_data == TERM_WORD);
        word_seen   = active && i_data_valid && (i_data != TERM_WORD);
        last_region = (region == 2'(NUM_REGIONS - 1));
        region_sel  = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            region_sel[i] = (region == 2'(i));
        end
    end

    always_comb begin
        state_next = state;
        if (!i_cpu_rst) begin
            state_next = HOLD;
        end else if (term_seen && last_region) begin
            state_next = DONE;
        end else if (state == HOLD) begin
            state_next = LOAD;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // addr_full records that the last address of the region has been written,
    // so later words are dropped instead of wrapping onto address 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_cpu_rst) begin
            addr           <= '0;
            addr_full      <= 1'b0;
            region         <= '0;
            o_we           <= '0;
            o_waddr        <= '0;
            o_wdata        <= '0;
            o_init_done    <= '0;
            o_all_done     <= 1'b0;
            o_overflow_err <= 1'b0;
        end else begin
            o_we <= '0;
            if (word_seen) begin
                if (addr_full) begin
                    o_overflow_err <= 1'b1;
                end else begin
                    o_we    <= region_sel;
                    o_waddr <= addr;
                    o_wdata <= i_data;
                    addr    <= addr + 1'b1;
                    if (addr == '1) begin
                        addr_full <= 1'b1;
                    end
                end
            end
            if (term_seen) begin
                o_init_done <= o_init_done | region_sel;
                addr        <= '0;
                addr_full   <= 1'b0;
                if (last_region) begin
                    o_all_done <= 1'b1;
                end else begin
                    region <= region + 2'd1;
                end
            end
        end
    end

    assign o_region = region;

endmodule

// File: tb/tb_riscq_mem_loader.sv
// Randomised scoreboard bench for riscq_mem_loader: a word-counting reference
// model predicts writes and flags, a negedge monitor checks every write.
module tb_riscq_mem_loader;

    localparam int              NR    = 3;
    localparam int              AW    = 5;
    localparam int              DW    = 32;
    localparam int              DEPTH = 1 << AW;
    localparam logic [DW-1:0]   TERM  = '1;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_cpu_rst;
    logic [DW-1:0]   i_data;
    logic            i_data_valid;
    logic [AW-1:0]   o_waddr;
    logic [DW-1:0]   o_wdata;
    logic [NR-1:0]   o_we;
    logic [NR-1:0]   o_init_done;
    logic            o_all_done;
    logic            o_overflow_err;
    logic [1:0]      o_region;

    riscq_mem_loader #(
        .NUM_REGIONS (NR),
        .ADDR_W      (AW),
        .DATA_W      (DW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_cpu_rst      (i_cpu_rst),
        .i_data         (i_data),
        .i_data_valid   (i_data_valid),
        .o_waddr        (o_waddr),
        .o_wdata        (o_wdata),
        .o_we           (o_we),
        .o_init_done    (o_init_done),
        .o_all_done     (o_all_done),
        .o_overflow_err (o_overflow_err),
        .o_region       (o_region)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int            region;
        int            addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t     exp_q[$];
    wr_t     mon_e;
    int      checks   = 0;
    int      failures = 0;

    // Reference model: which region is filling, how many words it holds, flags.
    int      m_region;
    int      m_count;
    bit      m_all;
    bit      m_ovf;
    bit [NR-1:0] m_init;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_region = 0;
        m_count  = 0;
        m_all    = 0;
        m_ovf    = 0;
        m_init   = '0;
    endtask

    task automatic model_step(input bit rst, input bit cpu, input bit v, input logic [DW-1:0] d);
        if (rst || !cpu) begin
            model_clear();
        end else if (!m_all && v) begin
            if (d == TERM) begin
                m_init[m_region] = 1'b1;
                m_count = 0;
                if (m_region == NR - 1) m_all = 1;
                else m_region++;
            end else if (m_count < DEPTH) begin
                exp_q.push_back('{m_region, m_count, d});
                m_count++;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit cpu, input bit v, input logic [DW-1:0] d);
        i_rst        = rst;
        i_cpu_rst    = cpu;
        i_data_valid = v;
        i_data       = d;
        @(posedge i_clk);
        model_step(rst, cpu, v, d);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        applyStimulus(1'b0, 1'b1, 1'b1, d);
    endtask

    function automatic logic [DW-1:0] rand_word();
        return DW'($urandom) & 32'h7FFF_FFFF;
    endfunction

    task automatic checkOutput(input string tag);
        @(negedge i_clk);
        #1;
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_init_done"}, 64'(o_init_done), 64'(m_init));
        check({tag, "_all_done"}, 64'(o_all_done), 64'(m_all));
        check({tag, "_overflow"}, 64'(o_overflow_err), 64'(m_ovf));
        check({tag, "_region"}, 64'(o_region), 64'(m_region));
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput(tag);
        check({tag, "_we"}, 64'(o_we), 64'd0);
        check({tag, "_waddr"}, 64'(o_waddr), 64'd0);
        check({tag, "_wdata"}, 64'(o_wdata), 64'd0);
    endtask

    task automatic reload(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b1, rand_word());
    endtask

    task automatic full_stream(input string tag);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 32; i++) send(DW'(i));
            send(TERM);
            checkOutput(tag);
        end
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(1, 0) == 1) applyStimulus(1'b0, 1'b1, 1'b0, TERM);
            send(rand_word());
        end
        send(TERM);
        checkOutput(tag);
    endtask

    // Monitor: every asserted write enable must match the oldest predicted write.
    always @(negedge i_clk) begin
        if (o_we !== '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write got we=%0h addr=%0h data=%0h expected no write",
                         o_we, o_waddr, o_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_we", 64'(o_we), 64'(1) << mon_e.region);
                check("write_addr", 64'(o_waddr), 64'(mon_e.addr));
                check("write_data", 64'(o_wdata), 64'(mon_e.data));
            end
        end
    end

    initial begin
        model_clear();
        i_rst = 1'b1; i_cpu_rst = 1'b1; i_data_valid = 1'b0; i_data = '0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, rand_word());
        checkZeroOutputs("reset");

        full_stream("stream1");

        send(DW'(5));
        send(DW'(6));
        send(TERM);
        checkOutput("done_ignore");

        reload(10);
        checkOutput("hold");
        full_stream("stream2");

        reload(2);
        for (int i = 0; i < DEPTH + 2; i++) send(rand_word());
        checkOutput("overflow");
        send(TERM);
        checkOutput("overflow_term");
        send(DW'(7));
        send(TERM);
        send(TERM);
        checkOutput("overflow_rest");

        reload(2);
        for (int i = 0; i < NR; i++) send(TERM);
        checkOutput("empty_regions");
        send(DW'(5));
        send(DW'(6));
        checkOutput("empty_after");

        reload(2);
        for (int i = 0; i < 10; i++) send(rand_word());
        applyStimulus(1'b1, 1'b1, 1'b1, rand_word());
        checkZeroOutputs("mid_reset");
        for (int i = 0; i < 5; i++) send(rand_word());
        send(TERM);
        checkOutput("after_reset");

        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(199, 0) == 0,
                          $urandom_range(49, 0) != 0,
                          1'($urandom_range(1, 0)),
                          ($urandom_range(7, 0) == 0) ? TERM : rand_word());
            if (n % 100 == 99) checkOutput("random");
        end
        checkOutput("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
